// File: rtl/pattern_sequencer.sv
// pattern_sequencer
//   Chooses which test-pattern source drives the pixel mux ahead of the HDMI
//   serialiser. A debounced push-button or an auto-cycle frame timer requests
//   the next pattern. Switches happen only on frame boundaries. After a switch
//   the new source gets a one-clock reset and one whole frame is shown black.
//
// Ports
//   i_pixclk     in   pixel clock, sole clock domain
//   i_reset_n    in   asynchronous active-low reset (synchronous release upstream)
//   i_btn_next   in   raw asynchronous push-button, active high
//   i_auto_en    in   auto-cycle enable, quasi-static
//   i_newframe   in   one-clock pulse at the start of each frame
//   o_sel        out  index of the pattern source feeding the pixel mux
//   o_blank      out  1 = pixel mux outputs black
//   o_src_reset  out  one-clock active-high reset to the pattern sources
//   o_busy       out  1 = switch pending or blank frame in progress
//   o_dbg_state  out  current FSM state (0 SHOW, 1 PEND, 2 BLANK)
//
// Handshake: there is no valid/ready pair here; i_newframe is a single-clock
// strobe, and a request (button or auto) is a single-clock strobe that is
// consumed in SHOW and dropped in PEND/BLANK.

module pattern_sequencer #(
  parameter int NUM_PATTERNS  = 4,
  parameter int SEL_BITS      = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter int AUTO_FRAMES   = 120
) (
  input  logic                i_pixclk,
  input  logic                i_reset_n,
  input  logic                i_btn_next,
  input  logic                i_auto_en,
  input  logic                i_newframe,
  output logic [SEL_BITS-1:0] o_sel,
  output logic                o_blank,
  output logic                o_src_reset,
  output logic                o_busy,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SHOW  = 2'd0,
    ST_PEND  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [SEL_BITS-1:0] SEL_LAST   = SEL_BITS'(NUM_PATTERNS - 1);
  localparam logic [7:0]          FRAME_LAST = 8'(AUTO_FRAMES - 1);

  state_t state;

  logic btn_meta, btn_sync;
  logic auto_meta, auto_sync;
  logic [DEBOUNCE_BITS-1:0] db_cnt;
  logic btn_db, btn_db_q;
  logic [7:0] frame_cnt;
  logic btn_req, auto_req, next_req;

  assign o_dbg_state = state;

  // Two-flop synchronisers for both asynchronous inputs.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
    end else begin
      btn_meta  <= i_btn_next;
      btn_sync  <= btn_meta;
      auto_meta <= i_auto_en;
      auto_sync <= auto_meta;
    end
  end

  // Debounce: count only while the synced input disagrees with the debounced
  // level; any agreement (a glitch ending) restarts the count. The level flips
  // once the disagreement has lasted 2**DEBOUNCE_BITS clocks.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (&db_cnt) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  // Only presses request a switch; releases are ignored.
  assign btn_req  = btn_db & ~btn_db_q;
  assign auto_req = (state == ST_SHOW) && auto_sync && i_newframe &&
                    (frame_cnt == FRAME_LAST);
  assign next_req = btn_req | auto_req;

  // Frames shown so far in the current SHOW period (auto mode only).
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_cnt <= '0;
    end else if (!auto_sync) begin
      frame_cnt <= '0;
    end else if (state == ST_SHOW) begin
      if (next_req) begin
        frame_cnt <= '0;
      end else if (i_newframe) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Sequencing FSM with registered outputs. A request that coincides with
  // i_newframe in SHOW only arms PEND; the switch waits for the next frame.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_BLANK;
      o_sel       <= '0;
      o_blank     <= 1'b1;
      o_src_reset <= 1'b1;
      o_busy      <= 1'b1;
    end else begin
      o_src_reset <= 1'b0;
      case (state)
        ST_SHOW: begin
          if (next_req) begin
            state  <= ST_PEND;
            o_busy <= 1'b1;
          end
        end
        ST_PEND: begin
          if (i_newframe) begin
            state       <= ST_BLANK;
            o_sel       <= (o_sel == SEL_LAST) ? '0 : o_sel + SEL_BITS'(1);
            o_src_reset <= 1'b1;
            o_blank     <= 1'b1;
          end
        end
        ST_BLANK: begin
          if (i_newframe) begin
            state   <= ST_SHOW;
            o_blank <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_BLANK;
          o_blank <= 1'b1;
          o_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer
//   Directed bench for pattern_sequencer with DEBOUNCE_BITS=4, AUTO_FRAMES=3
//   and a 100-clock frame. Expected pattern indices are queued as switches are
//   requested and checked when the DUT pulses o_src_reset.

module tb_pattern_sequencer;

  localparam int FRAME_CLKS = 100;

  logic       i_pixclk = 1'b0;
  logic       i_reset_n;
  logic       i_btn_next;
  logic       i_auto_en;
  logic       i_newframe;
  logic [1:0] o_sel;
  logic       o_blank;
  logic       o_src_reset;
  logic       o_busy;
  logic [1:0] o_dbg_state;

  pattern_sequencer #(
    .NUM_PATTERNS (4),
    .SEL_BITS     (2),
    .DEBOUNCE_BITS(4),
    .AUTO_FRAMES  (3)
  ) dut (
    .i_pixclk   (i_pixclk),
    .i_reset_n  (i_reset_n),
    .i_btn_next (i_btn_next),
    .i_auto_en  (i_auto_en),
    .i_newframe (i_newframe),
    .o_sel      (o_sel),
    .o_blank    (o_blank),
    .o_src_reset(o_src_reset),
    .o_busy     (o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock
  always #5 i_pixclk = ~i_pixclk;

  // scoreboard state
  logic [1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int phase = 50;
  logic prev_src = 1'b1;
  logic sw_prev = 1'b0;
  logic blank_arm = 1'b0;
  int blank_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, then sample outputs mid-cycle
  // and run the switch monitor.
  task automatic cycle();
    @(posedge i_pixclk);
    #1;
    i_newframe = (phase == 0);
    phase = (phase + 1) % FRAME_CLKS;
    #3;
    if (i_reset_n) begin
      if (sw_prev) chk("src_reset_width", o_src_reset, 0);
      sw_prev = 1'b0;
      if (o_src_reset && !prev_src) begin
        if (exp_q.size() == 0) chk("switch_expected", exp_q.size(), 1);
        else chk("switch_sel", o_sel, exp_q.pop_front());
        sw_prev   = 1'b1;
        blank_arm = 1'b1;
        blank_run = 0;
      end
      if (blank_arm) begin
        if (o_blank) blank_run++;
        else begin
          chk("blank_len", blank_run, FRAME_CLKS);
          blank_arm = 1'b0;
        end
      end
    end else begin
      sw_prev   = 1'b0;
      blank_arm = 1'b0;
    end
    prev_src = o_src_reset;
  endtask

  // Advance through the next i_newframe and one more clock so outputs reflect it.
  task automatic to_frame_edge();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!i_newframe && n < 2 * FRAME_CLKS);
    chk("frame_timeout", i_newframe, 1);
    cycle();
  endtask

  task automatic press(input int hold);
    i_btn_next = 1'b1;
    repeat (hold) cycle();
    i_btn_next = 1'b0;
    repeat (20) cycle();
  endtask

  task automatic press_switch(input logic [1:0] exp);
    exp_q.push_back(exp);
    press(20);
    chk("pend_busy", o_busy, 1);
    chk("pend_blank", o_blank, 0);
    to_frame_edge();
    chk("sw_sel", o_sel, exp);
    chk("sw_blank", o_blank, 1);
    chk("sw_busy", o_busy, 1);
    to_frame_edge();
    chk("show_sel", o_sel, exp);
    chk("show_blank", o_blank, 0);
    chk("show_busy", o_busy, 0);
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_btn_next = 1'b0;
    i_auto_en  = 1'b0;
    i_newframe = 1'b0;

    // 1: reset state and first frame
    repeat (3) @(posedge i_pixclk);
    #4;
    chk("rst_sel", o_sel, 0);
    chk("rst_blank", o_blank, 1);
    chk("rst_src_reset", o_src_reset, 1);
    chk("rst_busy", o_busy, 1);
    @(posedge i_pixclk);
    #1;
    i_reset_n = 1'b1;
    cycle();
    chk("rel_src_reset", o_src_reset, 0);
    chk("rel_blank", o_blank, 1);
    to_frame_edge();
    chk("first_blank", o_blank, 0);
    chk("first_sel", o_sel, 0);
    chk("first_busy", o_busy, 0);

    // 2: clean press -> 0 to 1
    press_switch(2'd1);

    // 3: glitchy button never qualifies
    for (int i = 0; i < 10; i++) begin
      i_btn_next = ~i_btn_next;
      repeat (3) cycle();
    end
    i_btn_next = 1'b0;
    repeat (20) cycle();
    chk("glitch_busy", o_busy, 0);
    to_frame_edge();
    chk("glitch_sel", o_sel, 1);
    chk("glitch_busy2", o_busy, 0);

    // walk to sel=3
    press_switch(2'd2);
    press_switch(2'd3);

    // 4: auto cycle 3 -> 0 -> 1 -> 2 -> 3
    i_auto_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(2'(k));
      for (int f = 0; f < 5; f++) begin
        to_frame_edge();
        if (f == 2) chk("auto_pend_busy", o_busy, 1);
        if (f == 4) begin
          chk("auto_sel", o_sel, k);
          chk("auto_blank", o_blank, 0);
        end
      end
    end
    i_auto_en = 1'b0;
    repeat (4) to_frame_edge();
    chk("auto_off_sel", o_sel, 3);
    chk("auto_off_busy", o_busy, 0);

    // 5a: second press during BLANK is dropped
    exp_q.push_back(2'd0);
    press(20);
    to_frame_edge();
    chk("blank_sel", o_sel, 0);
    press(20);
    chk("blank_press_busy", o_busy, 1);
    chk("blank_press_blank", o_blank, 1);
    to_frame_edge();
    to_frame_edge();
    chk("dropped_sel", o_sel, 0);
    chk("dropped_busy", o_busy, 0);

    // 5b: request lands on the same clock as i_newframe
    for (int i = 0; i < FRAME_CLKS && phase != 83; i++) cycle();
    exp_q.push_back(2'd1);
    press(20);
    chk("coin_busy", o_busy, 1);
    chk("coin_sel", o_sel, 0);
    chk("coin_blank", o_blank, 0);
    to_frame_edge();
    chk("coin_sw_sel", o_sel, 1);
    to_frame_edge();
    chk("coin_show_blank", o_blank, 0);

    // 6: reset while pending with sel=2
    press_switch(2'd2);
    i_btn_next = 1'b1;
    repeat (20) cycle();
    i_btn_next = 1'b0;
    repeat (3) cycle();
    chk("p6_busy", o_busy, 1);
    chk("p6_sel", o_sel, 2);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("async_sel", o_sel, 0);
    chk("async_blank", o_blank, 1);
    chk("async_src_reset", o_src_reset, 1);
    repeat (3) cycle();
    @(posedge i_pixclk);
    #1;
    i_reset_n = 1'b1;
    to_frame_edge();
    chk("post_rst_sel", o_sel, 0);
    chk("post_rst_blank", o_blank, 0);
    to_frame_edge();
    chk("post_rst_sel2", o_sel, 0);
    chk("post_rst_busy", o_busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
